// File: rtl/alu_result_queue_if.sv
// Handshake bundle between the ALU, the result queue and the writeback consumer.
// Valid/ready: a transfer occurs on a rising edge where valid && ready; the sender holds its payload stable while valid is high and ready is low.
interface alu_result_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_cout;
  logic        in_overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic        out_cout;
  logic        out_overflow;

  modport master (
    output in_valid, in_result, in_cout, in_overflow, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_cout, out_overflow
  );

  modport slave (
    input  in_valid, in_result, in_cout, in_overflow, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_cout, out_overflow
  );
endinterface

// File: rtl/alu_result_queue.sv
// In-order result queue behind the 32-bit ALU with a sticky overflow flag.
// Define ALU_RES_OVF_CNT_EN to build the saturating overflow event counter.
module alu_result_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n,
  alu_result_queue_if.slave        bus,
  input  logic                     flush,
  input  logic                     sticky_clr,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     sticky_ovf,
  output logic [CNT_W-1:0]         ovf_count,
  output logic [1:0]               occ_state
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  logic [33:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             sticky_q;
  logic             push;
  logic             pop;
  logic             ovf_push;
  logic [33:0]      head;
  occ_e             occ;

  // Occupancy class, decoded from the level register.
  always_comb begin
    occ = OCC_PARTIAL;
    if (level_q == '0)           occ = OCC_EMPTY;
    else if (level_q == FULL_LVL) occ = OCC_FULL;
  end

  assign occ_state    = occ;
  assign bus.in_ready = rst_n && (occ != OCC_FULL);
  assign bus.out_valid = (occ != OCC_EMPTY);
  assign push     = bus.in_valid && bus.in_ready;
  assign pop      = bus.out_valid && bus.out_ready;
  assign ovf_push = push && bus.in_overflow;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only observable while level covers them.
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr_q] <= {bus.in_result, bus.in_cout, bus.in_overflow};
  end

  // A push discarded by flush still records its overflow.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)          sticky_q <= 1'b0;
    else if (ovf_push)   sticky_q <= 1'b1;
    else if (sticky_clr) sticky_q <= 1'b0;
  end

`ifdef ALU_RES_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)                      ovf_cnt_q <= '0;
    else if (sticky_clr)             ovf_cnt_q <= ovf_push ? CNT_W'(1) : '0;
    else if (ovf_push && !(&ovf_cnt_q)) ovf_cnt_q <= ovf_cnt_q + CNT_W'(1);
  end

  assign ovf_count = ovf_cnt_q;
`else
  assign ovf_count = '0;
`endif

  assign head             = bus.out_valid ? mem[rd_ptr_q] : '0;
  assign bus.out_result   = head[33:2];
  assign bus.out_cout     = head[1];
  assign bus.out_overflow = head[0];
  assign bus.out_zero     = bus.out_valid && ~|head[33:2];
  assign level            = level_q;
  assign sticky_ovf       = sticky_q;
endmodule

// File: tb/tb_alu_result_queue.sv
// Directed plus randomized bench for alu_result_queue against a queue-based reference model.
module tb_alu_result_queue;
  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             sticky_clr = 1'b0;
  logic [LVL_W-1:0] level;
  logic             sticky_ovf;
  logic [CNT_W-1:0] ovf_count;
  logic [1:0]       occ_state;

  alu_result_queue_if bus ();

  alu_result_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i      (clk_i),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .sticky_clr (sticky_clr),
    .level      (level),
    .sticky_ovf (sticky_ovf),
    .ovf_count  (ovf_count),
    .occ_state  (occ_state)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: queue of {result, cout, overflow}
  logic [33:0] mq[$];
  logic        m_sticky = 1'b0;
  int          m_cnt = 0;
  int          n_pass = 0;
  int          n_total = 0;
  logic [31:0] words [4];
  logic [31:0] d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    logic        v;
    logic [33:0] h;
    v = (mq.size() > 0);
    h = v ? mq[0] : 34'd0;
    chk("out_valid",    32'(bus.out_valid),    32'(v));
    chk("out_result",   bus.out_result,        h[33:2]);
    chk("out_cout",     32'(bus.out_cout),     32'(h[1]));
    chk("out_overflow", 32'(bus.out_overflow), 32'(h[0]));
    chk("out_zero",     32'(bus.out_zero),     32'(v && (h[33:2] == 32'd0)));
    chk("level",        32'(level),            32'(mq.size()));
    chk("in_ready",     32'(bus.in_ready),     32'(mq.size() != DEPTH));
    chk("sticky_ovf",   32'(sticky_ovf),       32'(m_sticky));
    chk("ovf_count",    32'(ovf_count),        32'(m_cnt));
  endtask

  // Called just after a falling edge with inputs set; returns after the next falling edge.
  task automatic step();
    bit          push, pop, ovf;
    logic [33:0] e;
    check_outputs();
    push = bus.in_valid && (mq.size() < DEPTH);
    pop  = bus.out_ready && (mq.size() > 0);
    ovf  = push && bus.in_overflow;
    e    = {bus.in_result, bus.in_cout, bus.in_overflow};
    @(posedge clk_i);
    #1;
    if (flush) mq.delete();
    else begin
      if (pop)  e = e; // keep push payload captured before the edge
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    if (ovf) m_sticky = 1'b1;
    else if (sticky_clr) m_sticky = 1'b0;
`ifdef ALU_RES_OVF_CNT_EN
    if (sticky_clr) m_cnt = ovf ? 1 : 0;
    else if (ovf && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
`else
    m_cnt = 0;
`endif
    @(negedge clk_i);
  endtask

  task automatic drive(input logic v, input logic [31:0] r, input logic c, input logic o, input logic rdy);
    bus.in_valid    = v;
    bus.in_result   = r;
    bus.in_cout     = c;
    bus.in_overflow = o;
    bus.out_ready   = rdy;
  endtask

  initial begin
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level",     32'(level),         32'd0);
    chk("rst_sticky",    32'(sticky_ovf),    32'd0);
    rst_n = 1'b1;
    #1;
    check_outputs();

    // Single push then pop
    drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    chk("t1_result", bus.out_result, 32'h5);
    chk("t1_zero",   32'(bus.out_zero), 32'd0);
    chk("t1_level",  32'(level), 32'd1);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t1_empty_valid",  32'(bus.out_valid), 32'd0);
    chk("t1_empty_result", bus.out_result, 32'd0);
    step();

    // Fill to DEPTH, reject a fifth, drain in order
    words[0] = 32'h0000_0000; words[1] = 32'h7FFF_FFFF;
    words[2] = 32'h8000_0000; words[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, words[i], i[0], 1'b0, 1'b0);
      step();
    end
    chk("full_level",    32'(level), 32'd4);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'h1234, 1'b0, 1'b0, 1'b1);
    step();
    chk("full_after_pop_level", 32'(level), 32'd3);
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 4; i++) begin
      chk("drain_result", bus.out_result, words[i]);
      chk("drain_zero",   32'(bus.out_zero), 32'd0);
      step();
    end
    chk("drain_empty", 32'(bus.out_valid), 32'd0);

    // Streaming with level held at 1
    drive(1'b1, 32'hA5A5_0001, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      d = $urandom;
      drive(1'b1, d, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
      step();
      chk("stream_level",  32'(level), 32'd1);
      chk("stream_result", bus.out_result, d);
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    step();

    // Overflow push discarded by flush
    drive(1'b1, 32'h42, 1'b0, 1'b1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("flush_level",  32'(level), 32'd0);
    chk("flush_sticky", 32'(sticky_ovf), 32'd1);
`ifdef ALU_RES_OVF_CNT_EN
    chk("flush_count",  32'(ovf_count), 32'd1);
`else
    chk("flush_count",  32'(ovf_count), 32'd0);
`endif
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("clr_sticky", 32'(sticky_ovf), 32'd0);
    chk("clr_count",  32'(ovf_count), 32'd0);

    // Counter saturation and clear-versus-increment
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, $urandom, 1'b0, 1'b1, 1'b1);
      step();
    end
`ifdef ALU_RES_OVF_CNT_EN
    chk("sat_count", 32'(ovf_count), 32'd15);
`else
    chk("sat_count", 32'(ovf_count), 32'd0);
`endif
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    chk("clr_inc_sticky", 32'(sticky_ovf), 32'd1);
`ifdef ALU_RES_OVF_CNT_EN
    chk("clr_inc_count", 32'(ovf_count), 32'd1);
`else
    chk("clr_inc_count", 32'(ovf_count), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom_range(0, 3) == 0 ? 32'd0 : $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0));
      flush      = ($urandom_range(0, 19) == 0);
      sticky_clr = ($urandom_range(0, 9) == 0);
      step();
    end
    flush = 1'b0;
    sticky_clr = 1'b0;

    // Reset while holding three entries
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    while (mq.size() > 0) step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'(i + 7), 1'b0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("mid_level_before", 32'(level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(bus.in_ready),  32'd0);
    chk("mid_rst_level",    32'(level),         32'd0);
    chk("mid_rst_sticky",   32'(sticky_ovf),    32'd0);
    chk("mid_rst_count",    32'(ovf_count),     32'd0);
    mq.delete();
    m_sticky = 1'b0;
    m_cnt = 0;
    @(negedge clk_i);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b1, 32'h0, 1'b1, 1'b0, 1'b0);
    step();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
